// File: rtl/gem_roll_wg_sched.sv
// Batch sequencer for GEM roll -> CSC wiregroup lookups through a dual-port ROM.
// Issues up to two lookups per cycle (lowest pending pair) and captures the registered ROM data.
module gem_roll_wg_sched #(
  parameter int unsigned NCLUST = 8,
  parameter int unsigned MXADRB = 3,
  parameter int unsigned MXDATB = 7,
  parameter int unsigned WG_MAX = 48
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NCLUST-1:0]        clust_vld,
  input  logic [NCLUST*MXADRB-1:0] clust_roll,
  output logic [MXADRB-1:0]        rom_adr0,
  output logic [MXADRB-1:0]        rom_adr1,
  input  logic [MXDATB-1:0]        rom_rd0,
  input  logic [MXDATB-1:0]        rom_rd1,
  output logic [NCLUST*MXDATB-1:0] wg_out,
  output logic [NCLUST-1:0]        wg_vld,
  output logic                     done,
  output logic                     busy,
  output logic                     start_err,
  output logic                     range_err
);

  localparam int unsigned IW = (NCLUST > 1) ? $clog2(NCLUST) : 1;
  localparam logic [MXDATB-1:0] WG_LIM = MXDATB'(WG_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [NCLUST-1:0]          pend_q, pend_d;
  logic [NCLUST*MXADRB-1:0]   roll_q, roll_d;
  logic                       t0v_q, t0v_d, t1v_q, t1v_d;
  logic [IW-1:0]              t0i_q, t0i_d, t1i_q, t1i_d;
  logic [NCLUST*MXDATB-1:0]   wg_q, wg_d;
  logic [NCLUST-1:0]          vld_q, vld_d;
  logic                       done_q, done_d;
  logic                       serr_q, serr_d;
  logic                       rerr_q, rerr_d;

  logic          has_a, has_b;
  logic [IW-1:0] sel_a, sel_b;

  // Lowest and next-lowest pending slots.
  always_comb begin
    has_a = 1'b0;
    has_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NCLUST; i++) begin
      if (pend_q[i]) begin
        if (!has_a) begin
          has_a = 1'b1;
          sel_a = IW'(i);
        end else if (!has_b) begin
          has_b = 1'b1;
          sel_b = IW'(i);
        end
      end
    end
  end

  always_comb begin
    rom_adr0 = '0;
    rom_adr1 = '0;
    if (state_q == StIssue) begin
      rom_adr0 = roll_q[sel_a*MXADRB +: MXADRB];
      if (has_b) rom_adr1 = roll_q[sel_b*MXADRB +: MXADRB];
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    roll_d  = roll_q;
    t0v_d   = 1'b0;
    t0i_d   = '0;
    t1v_d   = 1'b0;
    t1i_d   = '0;
    wg_d    = wg_q;
    vld_d   = vld_q;
    rerr_d  = rerr_q;
    done_d  = 1'b0;
    serr_d  = start && (state_q != StIdle);

    // Out-of-range words are clamped and left invalid.
    if (t0v_q) begin
      if (rom_rd0 > WG_LIM) begin
        wg_d[t0i_q*MXDATB +: MXDATB] = WG_LIM;
        rerr_d = 1'b1;
      end else begin
        wg_d[t0i_q*MXDATB +: MXDATB] = rom_rd0;
        vld_d[t0i_q] = 1'b1;
      end
    end
    if (t1v_q) begin
      if (rom_rd1 > WG_LIM) begin
        wg_d[t1i_q*MXDATB +: MXDATB] = WG_LIM;
        rerr_d = 1'b1;
      end else begin
        wg_d[t1i_q*MXDATB +: MXDATB] = rom_rd1;
        vld_d[t1i_q] = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_d  = clust_vld;
          roll_d  = clust_roll;
          wg_d    = '0;
          vld_d   = '0;
          rerr_d  = 1'b0;
          state_d = (|clust_vld) ? StIssue : StDrain;
        end
      end
      StIssue: begin
        pend_d[sel_a] = 1'b0;
        if (has_b) pend_d[sel_b] = 1'b0;
        t0v_d = has_a;
        t0i_d = sel_a;
        t1v_d = has_b;
        t1i_d = has_b ? sel_b : '0;
        if (pend_d == '0) state_d = StDrain;
      end
      StDrain: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      roll_q  <= '0;
      t0v_q   <= 1'b0;
      t0i_q   <= '0;
      t1v_q   <= 1'b0;
      t1i_q   <= '0;
      wg_q    <= '0;
      vld_q   <= '0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      roll_q  <= roll_d;
      t0v_q   <= t0v_d;
      t0i_q   <= t0i_d;
      t1v_q   <= t1v_d;
      t1i_q   <= t1i_d;
      wg_q    <= wg_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      rerr_q  <= rerr_d;
    end
  end

  assign wg_out    = wg_q;
  assign wg_vld    = vld_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);
  assign start_err = serr_q;
  assign range_err = rerr_q;

endmodule

// File: tb/tb_gem_roll_wg_sched.sv
// Scoreboard bench for gem_roll_wg_sched: reference model computes per-batch results,
// address pairs and done timing; a monitor compares whenever busy/done are seen.
module tb_gem_roll_wg_sched;

  localparam int NC = 8;
  localparam int AB = 3;
  localparam int DB = 7;
  localparam int WGM = 48;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [NC-1:0]     clust_vld;
  logic [NC*AB-1:0]  clust_roll;
  logic [AB-1:0]     rom_adr0, rom_adr1;
  logic [DB-1:0]     rom_rd0, rom_rd1;
  logic [NC*DB-1:0]  wg_out;
  logic [NC-1:0]     wg_vld;
  logic              done, busy, start_err, range_err;

  gem_roll_wg_sched #(.NCLUST(NC), .MXADRB(AB), .MXDATB(DB), .WG_MAX(WGM)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .clust_vld  (clust_vld),
    .clust_roll (clust_roll),
    .rom_adr0   (rom_adr0),
    .rom_adr1   (rom_adr1),
    .rom_rd0    (rom_rd0),
    .rom_rd1    (rom_rd1),
    .wg_out     (wg_out),
    .wg_vld     (wg_vld),
    .done       (done),
    .busy       (busy),
    .start_err  (start_err),
    .range_err  (range_err)
  );

  always #5 clock = ~clock;

  // Behavioural dual-port ROM, one-cycle registered read.
  logic [DB-1:0] rom_mem [8];
  always @(posedge clock) begin
    rom_rd0 <= rom_mem[rom_adr0];
    rom_rd1 <= rom_mem[rom_adr1];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [NC*DB-1:0] wg;
    logic [NC-1:0]    vld;
    logic             rerr;
    int               done_cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [5:0]   addr_q[$];
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: address pairs while busy, batch results on done.
  always @(negedge clock) begin
    if (reset_n) begin
      if (busy) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL adr_extra: got busy cycle required none (t=%0t)", $time);
        end else begin
          logic [5:0] a;
          a = addr_q.pop_front();
          check("rom_adr_pair", {58'd0, rom_adr0, rom_adr1}, {58'd0, a});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got done=1 required 0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wg_out", {8'd0, wg_out}, {8'd0, e.wg});
          check("wg_vld", {56'd0, wg_vld}, {56'd0, e.vld});
          check("range_err", {63'd0, range_err}, {63'd0, e.rerr});
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("busy_at_done", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  // Reference model: valid slots in ascending order, paired two per cycle.
  task automatic issue_batch(input logic [NC-1:0] v, input logic [NC*AB-1:0] r);
    exp_t e;
    int   idx[$];
    int   k;
    logic [AB-1:0] a0, a1, rl;
    e.wg = '0; e.vld = '0; e.rerr = 1'b0;
    for (int i = 0; i < NC; i++) if (v[i]) idx.push_back(i);
    foreach (idx[j]) begin
      rl = r[idx[j]*AB +: AB];
      if (int'(rom_mem[rl]) > WGM) begin
        e.wg[idx[j]*DB +: DB] = DB'(WGM);
        e.rerr = 1'b1;
      end else begin
        e.wg[idx[j]*DB +: DB] = rom_mem[rl];
        e.vld[idx[j]] = 1'b1;
      end
    end
    k = idx.size();
    for (int j = 0; j < k; j += 2) begin
      a0 = r[idx[j]*AB +: AB];
      a1 = (j + 1 < k) ? r[idx[j+1]*AB +: AB] : '0;
      addr_q.push_back({a0, a1});
    end
    addr_q.push_back(6'd0);
    e.done_cyc = cyc + 1 + ((k == 0) ? 1 : (k + 1) / 2 + 1);
    exp_q.push_back(e);
    start = 1'b1; clust_vld = v; clust_roll = r;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout: got still busy required idle");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #2;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL wait_done_timeout: got no done required done");
    end
  endtask

  task automatic rom_linear();
    for (int i = 0; i < 8; i++) rom_mem[i] = DB'(6 * i);
  endtask

  logic [NC*AB-1:0] rolls;

  initial begin
    reset_n = 1'b0; start = 1'b0; clust_vld = '0; clust_roll = '0;
    rom_linear();
    #1;
    check("rst_outputs", {busy, done, start_err, range_err, wg_vld, wg_out}, 64'd0);
    check("rst_adr", {58'd0, rom_adr0, rom_adr1}, 64'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #2;

    // Full batch, rolls 0..7.
    for (int i = 0; i < NC; i++) rolls[i*AB +: AB] = AB'(i);
    issue_batch(8'hFF, rolls);
    wait_idle();

    // Sparse odd batch.
    rolls = '0;
    rolls[2*AB +: AB] = 3'd3; rolls[5*AB +: AB] = 3'd1; rolls[7*AB +: AB] = 3'd6;
    issue_batch(8'b1010_0100, rolls);
    wait_idle();

    // Empty batch.
    issue_batch(8'h00, $urandom());
    wait_idle();

    // Collision two cycles into a full batch, then back-to-back start on done.
    for (int i = 0; i < NC; i++) rolls[i*AB +: AB] = AB'(7 - i);
    issue_batch(8'hFF, rolls);
    @(posedge clock); #2;
    start = 1'b1; clust_vld = 8'h0F; clust_roll = $urandom();
    @(posedge clock); #1;
    check("start_err_pulse", {63'd0, start_err}, 64'd1);
    #1 start = 1'b0;
    @(posedge clock); #1;
    check("start_err_clear", {63'd0, start_err}, 64'd0);
    #1;
    wait_done();
    issue_batch(8'h3C, $urandom());
    wait_idle();

    // Range error on roll 4, sticky until next start.
    rom_mem[4] = 7'd60;
    for (int i = 0; i < NC; i++) rolls[i*AB +: AB] = AB'(i);
    issue_batch(8'hFF, rolls);
    wait_idle();
    repeat (3) @(posedge clock);
    #2 check("range_err_held", {63'd0, range_err}, 64'd1);
    check("range_slot_wg", {57'd0, wg_out[4*DB +: DB]}, 64'd48);
    rom_linear();
    issue_batch(8'h01, rolls);
    check("range_err_cleared", {63'd0, range_err}, 64'd0);
    wait_idle();

    // Reset during ISSUE.
    issue_batch(8'hFF, rolls);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, start_err, range_err, wg_vld, wg_out}, 64'd0);
    check("midrst_adr", {58'd0, rom_adr0, rom_adr1}, 64'd0);
    exp_q.delete(); addr_q.delete();
    @(posedge clock); #2 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #2 check("midrst_no_stale", {busy, done, wg_vld, wg_out}, 64'd0);
    issue_batch(8'b0110_1001, $urandom());
    wait_idle();

    // Randomized batches, ROM contents occasionally above WG_MAX.
    for (int it = 0; it < 40; it++) begin
      logic [NC-1:0] v;
      v = NC'($urandom());
      if ($urandom_range(0, 7) == 0) v = '0;
      if (it % 3 == 1) begin
        wait_done();
      end else begin
        wait_idle();
        for (int i = 0; i < 8; i++) rom_mem[i] = DB'($urandom_range(0, 56));
      end
      issue_batch(v, $urandom());
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gem_roll_wg_sched.md
Name: gem_roll_wg_sched

Overview:
- Sequences GEM-roll-to-CSC-wiregroup lookups through the existing dual-port roll→wiregroup ROM for one batch of GEM clusters.
- On each start, latches up to NCLUST cluster rolls and issues two lookups per cycle, one on each ROM read port, skipping empty slots.
- Collects the registered ROM data and presents per-cluster wiregroups with valid bits and a done strobe.
- Sits between GEM cluster finding and the GEM–CSC matching logic.

Parameters:
- NCLUST, 8, number of cluster slots per batch (even, 2..16).
- MXADRB, 3, roll address width; must match ROM.
- MXDATB, 7, wiregroup width; must match ROM.
- WG_MAX, 48, largest legal wiregroup (ME11).

Ports:
- clock  in  1  logic clock; ROM instance shares it, rising edge, 1-cycle read latency.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle batch start request.
- clust_vld  in  NCLUST  slot valid mask, sampled with start.
- clust_roll  in  NCLUST*MXADRB  slot i roll at [i*MXADRB +: MXADRB], sampled with start.
- rom_adr0  out  MXADRB  ROM port-0 address.
- rom_adr1  out  MXADRB  ROM port-1 address.
- rom_rd0  in  MXDATB  ROM port-0 data, 1 cycle after address.
- rom_rd1  in  MXDATB  ROM port-1 data, 1 cycle after address.
- wg_out  out  NCLUST*MXDATB  slot i wiregroup at [i*MXDATB +: MXDATB].
- wg_vld  out  NCLUST  slot i wiregroup valid.
- done  out  1  one-cycle pulse: batch results complete.
- busy  out  1  batch in progress.
- start_err  out  1  one-cycle pulse: start rejected while busy.
- range_err  out  1  sticky: a ROM word exceeded WG_MAX; cleared by next accepted start.

Behaviour:
- Reset (async, any time, including mid-batch):
  - wg_out=0, wg_vld=0, done=0, busy=0, start_err=0, range_err=0.
  - Pending mask=0, tag pipeline cleared, state=IDLE.
  - rom_adr0/1 = 0.
  - In-flight ROM data is discarded after reset release.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 at edge E0 latches clust_vld into the pending mask and clust_roll into the roll registers.
  - Clears wg_vld and range_err; busy=1.
  - Goes to ISSUE if the mask is nonzero, otherwise DRAIN.
- ISSUE, each cycle:
  - Selects the lowest pending index a, and the next-lowest pending index b if one exists.
  - rom_adr0 = roll[a] (combinational); rom_adr1 = roll[b], or 0 if no b.
  - At the edge: clears a and b from pending; loads tag0={1,a} and tag1={b exists,b}.
  - Goes to DRAIN when pending becomes empty.
- DRAIN:
  - Waits one cycle for the last ROM data, then returns to IDLE.
  - busy drops at the same edge done rises.
- Capture, every edge with a tag valid (the cycle after issue):
  - wg_out[tagN] = rom_rdN and wg_vld[tagN] = 1.
  - If rom_rdN > WG_MAX: store wg_out=WG_MAX, leave wg_vld[tagN]=0, set range_err.
- Latency, with k = popcount(clust_vld) and m = ceil(k/2):
  - k≥1: ISSUE occupies m cycles after E0; done rises at edge E(m+1).
  - k=0: done rises at E1; no ROM access.
- wg_out / wg_vld hold until the next accepted start.
  - Slots with clust_vld=0 keep wg_vld=0; wg_out for those slots is 0 (cleared at start).
- start while busy: ignored; start_err pulses the next cycle; the batch in progress is unaffected.
- start in the same cycle done is asserted: busy is already 0 at that edge, so it is accepted.
- Tag pipeline uses one register stage and must match the ROM's 1-cycle latency.
  - The ROM is instantiated with FALLING_EDGE=0.
- Port order is fixed:
  - Port 0 always carries the lower index of the pair.
  - An odd final lookup uses port 0 only.
- done is registered; there are no combinational paths from inputs to done, wg_out or wg_vld.

Test Plan:
- Full batch:
  - Stimulus: clust_vld=8'hFF, rolls 0..7, ROM holds wg=6*roll.
  - Required: address pairs (0,1),(2,3),(4,5),(6,7) on consecutive cycles; done at E5; wg_out = 0,6,12,...,42; wg_vld=8'hFF.
- Sparse odd batch:
  - Stimulus: clust_vld=8'b1010_0100, rolls slot2=3, slot5=1, slot7=6.
  - Required: pair (roll3, roll1), then port0=roll6 with rom_adr1=0; done at E3; wg_vld=8'b1010_0100.
- Empty batch:
  - Stimulus: clust_vld=0.
  - Required: no address change from 0; done at E1; wg_vld=0.
- Busy collision:
  - Stimulus: start again 2 cycles into a full batch.
  - Required: start_err one-cycle pulse; first batch completes unchanged at E5.
  - Back-to-back start on the done cycle is accepted.
- Range error:
  - Stimulus: ROM word for roll 4 = 7'd60.
  - Required: that slot wg_out=48, wg_vld=0, range_err=1 and held until the next start.
- Reset mid-batch:
  - Stimulus: reset_n low during ISSUE.
  - Required: all outputs 0 immediately; after release, no done and no stale capture; a new start behaves as from reset.
